// File: rtl/dmac_ctrl_slv_if.sv
// AXI4-Lite control bus for the DMA controller register slave.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R).
//   master modport: host side, drives valids/addresses/data and B/R readies.
//   slave modport : register block side, drives AW/W/AR readies and B/R responses.
interface dmac_ctrl_slv_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/dmac_ctrl_slv.sv
// AXI4-Lite control-register slave in front of the DMA engine.
// Host programs BYTE_LEN / SRC / DST and writes START; the block pulses eng_start
// for one cycle, holds the operands static, tracks BUSY and keeps a sticky DONE.
// Ports:
//   ap_clk, ap_rst    clock, asynchronous active-high reset
//   s_axi_control     AXI4-Lite slave (dmac_ctrl_slv_if.slave)
//   eng_start         1-cycle start pulse to the engine
//   eng_done          1-cycle completion pulse from the engine
//   eng_byte_len      transfer length in bytes
//   eng_src_addr      source address (32-byte aligned)
//   eng_dst_addr      destination address (32-byte aligned)
module dmac_ctrl_slv #(
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 12,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    dmac_ctrl_slv_if.slave s_axi_control,
    output logic           eng_start,
    input  logic           eng_done,
    output logic [31:0]    eng_byte_len,
    output logic [31:0]    eng_src_addr,
    output logic [31:0]    eng_dst_addr
);
    if (C_S_AXI_CONTROL_DATA_WIDTH != 32) begin : g_bad_dw
        $error("dmac_ctrl_slv supports only a 32-bit control data width");
    end
    if (C_S_AXI_CONTROL_ADDR_WIDTH < 6) begin : g_bad_aw
        $error("dmac_ctrl_slv needs at least 6 control address bits");
    end

    localparam logic [5:0] A_CTRL = 6'h10;
    localparam logic [5:0] A_LEN  = 6'h14;
    localparam logic [5:0] A_SRC  = 6'h18;
    localparam logic [5:0] A_DST  = 6'h1C;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFE0;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;

    logic        aw_got, w_got;
    logic [5:0]  aw_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] byte_len, src_addr, dst_addr;
    logic        busy, done;
    logic [31:0] rdata_q, rd_mux;

    logic        aw_hs, w_hs, ar_hs, wr_fire, busy_eff;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
        return v;
    endfunction

    assign aw_hs = s_axi_control.awvalid & s_axi_control.awready;
    assign w_hs  = s_axi_control.wvalid  & s_axi_control.wready;
    assign ar_hs = s_axi_control.arvalid & s_axi_control.arready;

    // A write commits on the edge where the later of the two beats lands;
    // the beat arriving on that edge is taken straight from the bus.
    assign wr_fire = (w_state == W_IDLE) & (aw_got | aw_hs) & (w_got | w_hs);
    assign wr_addr = aw_got ? aw_addr_q : s_axi_control.awaddr[5:0];
    assign wr_data = w_got  ? wdata_q   : s_axi_control.wdata;
    assign wr_strb = w_got  ? wstrb_q   : s_axi_control.wstrb;

    // Completion is handled before a coincident START so the START sees an idle engine.
    assign busy_eff = busy & ~eng_done;

    // ---------------- write FSM ----------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (wr_fire) w_next = W_RESP;
            W_RESP: if (s_axi_control.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_control.awready = (w_state == W_IDLE) & ~aw_got;
        s_axi_control.wready  = (w_state == W_IDLE) & ~w_got;
        s_axi_control.bvalid  = (w_state == W_RESP);
        s_axi_control.bresp   = 2'b00;
    end

    // Hold whichever beat arrives first until its partner shows up.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (wr_fire) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= s_axi_control.awaddr[5:0];
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wdata_q <= s_axi_control.wdata;
                wstrb_q <= s_axi_control.wstrb;
            end
        end
    end

    // ---------------- registers / engine handshake ----------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            byte_len  <= '0;
            src_addr  <= '0;
            dst_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eng_start <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            if (busy && eng_done) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (wr_fire && !busy_eff) begin
                case (wr_addr)
                    A_CTRL: if (wr_strb[0] && wr_data[0]) begin
                        if (byte_len != 32'd0) begin
                            eng_start <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end else begin
                            done      <= 1'b1;   // zero-length op completes instantly
                        end
                    end
                    A_LEN: byte_len <= merge(byte_len, wr_data, wr_strb);
                    A_SRC: src_addr <= merge(src_addr, wr_data, wr_strb) & ALIGN_MASK;
                    A_DST: dst_addr <= merge(dst_addr, wr_data, wr_strb) & ALIGN_MASK;
                    default: ;
                endcase
            end
        end
    end

    assign eng_byte_len = byte_len;
    assign eng_src_addr = src_addr;
    assign eng_dst_addr = dst_addr;

    // ---------------- read FSM ----------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (s_axi_control.arvalid) r_next = R_DATA;
            R_DATA: if (s_axi_control.rready)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_control.arready = (r_state == R_IDLE);
        s_axi_control.rvalid  = (r_state == R_DATA);
        s_axi_control.rdata   = rdata_q;
        s_axi_control.rresp   = 2'b00;
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_control.araddr[5:0])
            A_CTRL:  rd_mux = {29'd0, ~busy, done, busy};
            A_LEN:   rd_mux = byte_len;
            A_SRC:   rd_mux = src_addr;
            A_DST:   rd_mux = dst_addr;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)     rdata_q <= '0;
        else if (ar_hs) rdata_q <= rd_mux;
    end
endmodule

// File: tb/tb_dmac_ctrl_slv.sv
// Self-checking bench for dmac_ctrl_slv: directed AXI4-Lite traffic, a
// transaction-level register model, and a per-cycle compare of engine outputs.
module tb_dmac_ctrl_slv;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic [31:0] eng_byte_len, eng_src_addr, eng_dst_addr;

    always #5 ap_clk = ~ap_clk;

    dmac_ctrl_slv_if #(.AW(12), .DW(32)) axi ();

    dmac_ctrl_slv #(
        .C_S_AXI_CONTROL_ADDR_WIDTH(12),
        .C_S_AXI_CONTROL_DATA_WIDTH(32)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .s_axi_control(axi),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_byte_len (eng_byte_len),
        .eng_src_addr (eng_src_addr),
        .eng_dst_addr (eng_dst_addr)
    );

    int checks = 0;
    int failures = 0;

    // Model state, updated once per completed transaction / done pulse.
    logic [31:0] m_len = '0, m_src = '0, m_dst = '0;
    bit          m_busy = 0, m_done = 0;
    int          exp_starts = 0;
    int          start_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bytes_upd(input logic [31:0] o, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] v;
        v = o;
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_busy) return;  // everything is ignored while an op is running
        case (a[5:0])
            6'h10: if (s[0] && d[0]) begin
                if (m_len != 0) begin m_busy = 1; m_done = 0; exp_starts++; end
                else m_done = 1;
            end
            6'h14: m_len = bytes_upd(m_len, d, s);
            6'h18: m_src = {bytes_upd(m_src, d, s)[31:5], 5'd0};
            6'h1C: m_dst = {bytes_upd(m_dst, d, s)[31:5], 5'd0};
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a[5:0])
            6'h10:   return m_busy ? 32'h1 : (m_done ? 32'h6 : 32'h4);
            6'h14:   return m_len;
            6'h18:   return m_src;
            6'h1C:   return m_dst;
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle compare of engine-facing outputs against the model.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (eng_start === 1'b1) start_seen++;
            chk("start_count", start_seen, exp_starts);
            chk("eng_byte_len", eng_byte_len, m_len);
            chk("eng_src_addr", eng_src_addr, m_src);
            chk("eng_dst_addr", eng_dst_addr, m_dst);
            if (axi.bvalid) chk("bresp", {30'd0, axi.bresp}, 32'd0);
            if (axi.rvalid) chk("rresp", {30'd0, axi.rresp}, 32'd0);
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        fork
            begin : aw_chan
                logic rdy;
                if (aw_dly > 0) begin repeat (aw_dly) @(posedge ap_clk); #1; end
                axi.awvalid = 1'b1; axi.awaddr = a;
                for (int n = 0; ; n++) begin
                    @(negedge ap_clk); rdy = axi.awready;
                    @(posedge ap_clk); #1;
                    if (rdy) break;
                    if (n > 50) begin chk("aw_timeout", 32'd0, 32'd1); break; end
                end
                axi.awvalid = 1'b0;
            end
            begin : w_chan
                logic rdy;
                if (w_dly > 0) begin repeat (w_dly) @(posedge ap_clk); #1; end
                axi.wvalid = 1'b1; axi.wdata = d; axi.wstrb = s;
                for (int n = 0; ; n++) begin
                    @(negedge ap_clk); rdy = axi.wready;
                    @(posedge ap_clk); #1;
                    if (rdy) break;
                    if (n > 50) begin chk("w_timeout", 32'd0, 32'd1); break; end
                end
                axi.wvalid = 1'b0;
            end
        join
        model_write(a, d, s);
        chk("bvalid_on_commit", {31'd0, axi.bvalid}, 32'd1);
        chk("bresp_on_commit", {30'd0, axi.bresp}, 32'd0);
        for (int i = 0; i < b_dly; i++) begin
            @(posedge ap_clk); #1;
            chk("bvalid_held", {31'd0, axi.bvalid}, 32'd1);
            chk("awready_in_resp", {31'd0, axi.awready}, 32'd0);
        end
        axi.bready = 1'b1;
        @(posedge ap_clk); #1;
        axi.bready = 1'b0;
        chk("bvalid_drop", {31'd0, axi.bvalid}, 32'd0);
        chk("ready_back", {30'd0, axi.awready, axi.wready}, 32'd3);
    endtask

    task automatic axi_read(input logic [11:0] a, input int r_dly, output logic [31:0] d);
        logic [31:0] exp;
        logic rdy;
        exp = model_read(a);
        axi.arvalid = 1'b1; axi.araddr = a;
        for (int n = 0; ; n++) begin
            @(negedge ap_clk); rdy = axi.arready;
            @(posedge ap_clk); #1;
            if (rdy) break;
            if (n > 50) begin chk("ar_timeout", 32'd0, 32'd1); break; end
        end
        axi.arvalid = 1'b0;
        chk("rvalid_after_ar", {31'd0, axi.rvalid}, 32'd1);
        d = axi.rdata;
        chk($sformatf("rdata_model_%02h", a), d, exp);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge ap_clk); #1;
            chk("rvalid_held", {31'd0, axi.rvalid}, 32'd1);
            chk("rdata_stable", axi.rdata, d);
        end
        axi.rready = 1'b1;
        @(posedge ap_clk); #1;
        axi.rready = 1'b0;
        chk("rvalid_drop", {31'd0, axi.rvalid}, 32'd0);
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        @(posedge ap_clk); #1;
        eng_done = 1'b0;
        if (m_busy) begin m_busy = 0; m_done = 1; end
    endtask

    logic [31:0] rd;

    initial begin
        axi.awvalid = 0; axi.awaddr = '0; axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0;
        axi.bready = 0; axi.arvalid = 0; axi.araddr = '0; axi.rready = 0;

        // Reset values
        repeat (2) @(posedge ap_clk); #1;
        chk("rst_readies", {29'd0, axi.awready, axi.wready, axi.arready}, 32'h7);
        chk("rst_valids", {30'd0, axi.bvalid, axi.rvalid}, 32'h0);
        chk("rst_eng_start", {31'd0, eng_start}, 32'h0);
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        axi_read(12'h010, 0, rd); chk("ctrl_after_reset", rd, 32'h4);

        // 1: program and start
        axi_write(12'h014, 32'd16384,     4'hF, 0, 0, 0);
        axi_write(12'h018, 32'h2000_0000, 4'hF, 0, 0, 0);
        axi_write(12'h01C, 32'h3000_0000, 4'hF, 0, 0, 0);
        axi_write(12'h010, 32'h1,         4'hF, 0, 0, 0);
        repeat (2) @(posedge ap_clk); #1;
        chk("t1_len", eng_byte_len, 32'd16384);
        chk("t1_src", eng_src_addr, 32'h2000_0000);
        chk("t1_dst", eng_dst_addr, 32'h3000_0000);
        chk("t1_one_pulse", start_seen, 32'd1);
        axi_read(12'h010, 0, rd); chk("t1_ctrl_busy", rd, 32'h1);

        // 2: completion, sticky DONE, restart clears DONE
        pulse_done();
        axi_read(12'h010, 0, rd); chk("t2_ctrl_done", rd, 32'h6);
        repeat (5) @(posedge ap_clk); #1;
        axi_read(12'h010, 0, rd); chk("t2_ctrl_sticky", rd, 32'h6);
        axi_write(12'h010, 32'h1, 4'h1, 0, 0, 0);
        axi_read(12'h010, 0, rd); chk("t2_ctrl_restart", rd, 32'h1);
        pulse_done();
        pulse_done();   // spurious pulse while idle is ignored
        axi_read(12'h010, 0, rd); chk("t2_ctrl_done2", rd, 32'h6);

        // 3: AW/W ordering, bvalid held under bready low
        axi_write(12'h014, 32'd100,       4'hF, 0, 3, 0);
        axi_write(12'h018, 32'h4000_0040, 4'hF, 3, 0, 0);
        axi_write(12'h01C, 32'h5000_009F, 4'hF, 0, 0, 4);
        axi_read(12'h014, 0, rd); chk("t3_len", rd, 32'd100);
        axi_read(12'h018, 0, rd); chk("t3_src", rd, 32'h4000_0040);
        axi_read(12'h01C, 0, rd); chk("t3_dst_masked", rd, 32'h5000_0080);
        chk("t3_no_pulse", start_seen, 32'd2);

        // 4: writes while busy ignored, strb-gated START, zero-length START
        axi_write(12'h010, 32'h1, 4'hF, 0, 0, 0);
        axi_write(12'h010, 32'h1, 4'hF, 0, 0, 0);
        axi_write(12'h018, 32'hDEAD_0000, 4'hF, 0, 0, 0);
        chk("t4_single_pulse", start_seen, 32'd3);
        axi_read(12'h018, 0, rd); chk("t4_src_kept", rd, 32'h4000_0040);
        pulse_done();
        axi_write(12'h010, 32'h1, 4'hE, 0, 0, 0);
        axi_read(12'h010, 0, rd); chk("t4_strb_gated", rd, 32'h6);
        axi_write(12'h014, 32'd0, 4'hF, 0, 0, 0);
        axi_write(12'h010, 32'h1, 4'hF, 0, 0, 0);
        axi_read(12'h010, 0, rd); chk("t4_zero_len", rd, 32'h6);
        chk("t4_zero_len_no_pulse", start_seen, 32'd3);

        // 5: partial strobes, unmapped read, rvalid hold
        axi_write(12'h018, 32'h0, 4'hF, 0, 0, 0);
        axi_write(12'h018, 32'h1234_567F, 4'h3, 0, 0, 0);
        axi_read(12'h018, 0, rd); chk("t5_src_strb", rd, 32'h0000_5660);
        axi_write(12'h03C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_read(12'h03C, 3, rd); chk("t5_unmapped", rd, 32'h0);

        // 6: reset mid-op with bvalid pending
        axi_write(12'h014, 32'd64, 4'hF, 0, 0, 0);
        axi.awvalid = 1; axi.awaddr = 12'h010; axi.wvalid = 1; axi.wdata = 32'h1; axi.wstrb = 4'hF;
        @(posedge ap_clk); #1;
        axi.awvalid = 0; axi.wvalid = 0;
        model_write(12'h010, 32'h1, 4'hF);
        chk("t6_bvalid_pending", {31'd0, axi.bvalid}, 32'd1);
        repeat (2) @(posedge ap_clk);
        #3;
        ap_rst = 1'b1;
        m_len = 0; m_src = 0; m_dst = 0; m_busy = 0; m_done = 0;
        #1;
        chk("t6_readies", {29'd0, axi.awready, axi.wready, axi.arready}, 32'h7);
        chk("t6_valids", {30'd0, axi.bvalid, axi.rvalid}, 32'h0);
        chk("t6_eng_start", {31'd0, eng_start}, 32'h0);
        chk("t6_operands", eng_byte_len | eng_src_addr | eng_dst_addr, 32'h0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        axi_read(12'h010, 0, rd); chk("t6_ctrl_idle", rd, 32'h4);
        chk("t6_total_pulses", start_seen, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
